// File: rtl/bk_pkg.sv
// Shared constants for the bk_timer block: register map, CSR bit positions,
// defaults and the byte-lane merge used for bus writes.
package bk_pkg;

  localparam logic [15:0] BASE_ADDR_DEFAULT = 16'o177706;
  localparam logic [15:0] VECTOR_DEFAULT    = 16'o000100;
  localparam int          PRESCALE_DEFAULT  = 128;
  localparam int          DIV16_FACTOR      = 16;

  // Register offsets from BASE_ADDR (byte addresses, word aligned)
  localparam logic [15:0] OFS_RELOAD = 16'd0;
  localparam logic [15:0] OFS_COUNT  = 16'd2;
  localparam logic [15:0] OFS_CSR    = 16'd4;

  // CSR bit positions
  localparam int CSR_RUN     = 0;
  localparam int CSR_ONESHOT = 1;
  localparam int CSR_IE      = 2;
  localparam int CSR_DIV     = 3;
  localparam int CSR_EXP     = 7;

  // Implemented CSR bits; everything else reads back as 0
  localparam logic [15:0] CSR_MASK = 16'h008F;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RELOAD,
    REG_COUNT,
    REG_CSR
  } reg_sel_e;

  // Apply a bus write to an existing register value. The initiator has
  // already replicated the byte onto both lanes, so a byte write just picks
  // the lane selected by the odd/even address bit.
  function automatic logic [15:0] bus_merge(input logic [15:0] old_val,
                                            input logic [15:0] wdata,
                                            input logic        byte_op,
                                            input logic        hi_byte);
    logic [15:0] res;
    res = wdata;
    if (byte_op) begin
      if (hi_byte) res = {wdata[15:8], old_val[7:0]};
      else         res = {old_val[15:8], wdata[7:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/bk_timer_prescaler.sv
// Count-tick prescaler: divides ce-edges by PRESCALE, or PRESCALE*16 when
// div16 is set. clr holds the counter at 0 (timer stopped or just started).
module bk_timer_prescaler
  import bk_pkg::*;
#(
  parameter int PRESCALE = PRESCALE_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ce,
  input  logic clr,
  input  logic div16,
  output logic tick
);

  localparam int MAX_PERIOD = PRESCALE * DIV16_FACTOR;
  localparam int CW         = $clog2(MAX_PERIOD);
  localparam logic [CW-1:0] TC_NORM = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] TC_DIV  = CW'(MAX_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] tc;
  logic          at_tc;

  // Terminal-count compare and next count; >= keeps a DIV change mid-period
  // from running the counter all the way around.
  always_comb begin
    tc    = div16 ? TC_DIV : TC_NORM;
    at_tc = (cnt_q >= tc);
    tick  = ce & ~clr & at_tc;
    cnt_d = cnt_q + CW'(1);
    if (clr || at_tc) cnt_d = '0;
  end

  // Prescaler count register, advances on ce-edges only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt_q <= '0;
    else if (ce)   cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bk_timer.sv
// Bus-attached interval timer with RELOAD / COUNT / CSR registers and a
// vectored interrupt. Bus replies, register writes and timer state all
// advance on ce-edges of clk.
module bk_timer
  import bk_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          PRESCALE  = PRESCALE_DEFAULT,
  parameter logic [15:0] VECTOR    = VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic [15:0] addr_i,
  input  logic [15:0] data_i,
  input  logic        sync_i,
  input  logic        din_i,
  input  logic        dout_i,
  input  logic        wtbt_i,
  input  logic        iako_i,
  output logic [15:0] data_o,
  output logic        sel_o,
  output logic        rply_o,
  output logic        virq_o
);

  localparam logic [15:0] A_RELOAD = BASE_ADDR + OFS_RELOAD;
  localparam logic [15:0] A_COUNT  = BASE_ADDR + OFS_COUNT;
  localparam logic [15:0] A_CSR    = BASE_ADDR + OFS_CSR;

  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q,  count_d;
  logic [15:0] csr_q,    csr_d;
  logic        irq_q,    irq_d;
  logic        rply_q,   rply_d;
  logic        sync_q;

  reg_sel_e    reg_sel;
  logic        hit;
  logic        ack_req;
  logic        rply_set;
  logic        wr_en;
  logic        wr_csr;
  logic [15:0] rdata;
  logic [15:0] csr_w;
  logic        run_start;
  logic        presc_clr;
  logic        tick;
  logic        expire;

  // Address decode and bus handshake qualifiers
  always_comb begin
    reg_sel = REG_NONE;
    if (sync_i) begin
      if      (addr_i[15:1] == A_RELOAD[15:1]) reg_sel = REG_RELOAD;
      else if (addr_i[15:1] == A_COUNT[15:1])  reg_sel = REG_COUNT;
      else if (addr_i[15:1] == A_CSR[15:1])    reg_sel = REG_CSR;
    end
    hit      = (reg_sel != REG_NONE);
    ack_req  = iako_i & irq_q;
    // Reply only on the first ce-edge of a bus cycle (rising SYNC)
    rply_set = sync_i & ~sync_q & (hit | ack_req);
    wr_en    = rply_set & dout_i & hit;
    wr_csr   = wr_en & (reg_sel == REG_CSR);
  end

  // Read mux; the vector takes priority during an acknowledge
  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_RELOAD: rdata = reload_q;
      REG_COUNT:  rdata = count_q;
      REG_CSR:    rdata = csr_q;
      default:    rdata = '0;
    endcase
    sel_o  = (hit & din_i) | (ack_req & din_i);
    data_o = '0;
    if (ack_req && din_i)  data_o = VECTOR;
    else if (hit && din_i) data_o = rdata;
  end

  bk_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .clr     (presc_clr),
    .div16   (csr_q[CSR_DIV]),
    .tick    (tick)
  );

  // Register writes, count/expiry sequencing and interrupt pending state
  always_comb begin
    reload_d = reload_q;
    if (wr_en && reg_sel == REG_RELOAD)
      reload_d = bus_merge(reload_q, data_i, wtbt_i, addr_i[0]);

    csr_w = csr_q;
    if (wr_csr)
      csr_w = bus_merge(csr_q, data_i, wtbt_i, addr_i[0]) & CSR_MASK;

    run_start = csr_w[CSR_RUN] & ~csr_q[CSR_RUN];
    // Stopped timers keep the prescaler parked at 0; a start restarts it
    presc_clr = ~csr_q[CSR_RUN] | run_start;
    expire    = tick & (count_q == 16'd0);

    count_d = count_q;
    if (run_start) begin
      count_d = reload_q;
    end else if (tick) begin
      if (expire) count_d = csr_w[CSR_ONESHOT] ? 16'd0 : reload_q;
      else        count_d = count_q - 16'd1;
    end

    // Expiry wins over a same-edge write of EXP=0
    csr_d = csr_w;
    if (expire) begin
      csr_d[CSR_EXP] = 1'b1;
      if (csr_w[CSR_ONESHOT]) csr_d[CSR_RUN] = 1'b0;
    end

    irq_d = irq_q;
    if ((rply_set && iako_i) || (wr_csr && !csr_w[CSR_IE])) irq_d = 1'b0;
    if (expire && csr_w[CSR_IE]) irq_d = 1'b1;

    rply_d = rply_q;
    if (!sync_i)       rply_d = 1'b0;
    else if (rply_set) rply_d = 1'b1;
  end

  // State registers, updated on ce-edges only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reload_q <= '0;
      count_q  <= '0;
      csr_q    <= '0;
      irq_q    <= 1'b0;
      rply_q   <= 1'b0;
      sync_q   <= 1'b0;
    end else if (ce) begin
      reload_q <= reload_d;
      count_q  <= count_d;
      csr_q    <= csr_d;
      irq_q    <= irq_d;
      rply_q   <= rply_d;
      sync_q   <= sync_i;
    end
  end

  assign rply_o = rply_q;
  assign virq_o = irq_q;

endmodule

// File: tb/tb_bk_timer.sv
// Directed bench for bk_timer: bus tasks push expected read data into a
// scoreboard queue; a monitor pops and compares when the DUT drives sel_o.
module tb_bk_timer;

  localparam logic [15:0] A_RELOAD = 16'o177706;
  localparam logic [15:0] A_COUNT  = 16'o177710;
  localparam logic [15:0] A_CSR    = 16'o177712;
  localparam logic [15:0] VEC      = 16'o000100;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [15:0] addr_i;
  logic [15:0] data_i;
  logic        sync_i, din_i, dout_i, wtbt_i, iako_i;
  logic [15:0] data_o;
  logic        sel_o, rply_o, virq_o;

  int n_pass  = 0;
  int n_total = 0;

  string       exp_name[$];
  logic [15:0] exp_val[$];

  bk_timer #(
    .BASE_ADDR (16'o177706),
    .PRESCALE  (4),
    .VECTOR    (16'o000100)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .addr_i  (addr_i),
    .data_i  (data_i),
    .sync_i  (sync_i),
    .din_i   (din_i),
    .dout_i  (dout_i),
    .wtbt_i  (wtbt_i),
    .iako_i  (iako_i),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .rply_o  (rply_o),
    .virq_o  (virq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Monitor: one capture per bus cycle, on the negedge before the reply
  initial begin : monitor
    bit          captured;
    string       nm;
    logic [15:0] v;
    captured = 1'b0;
    forever begin
      @(negedge clk);
      if (!sync_i) begin
        captured = 1'b0;
      end else if (sel_o && !rply_o && !captured && reset_n) begin
        captured = 1'b1;
        if (exp_val.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_read: got %h, expected no read", data_o);
        end else begin
          nm = exp_name.pop_front();
          v  = exp_val.pop_front();
          check(nm, data_o, v);
        end
      end
    end
  end

  task automatic wait_rply(input string nm, output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!rply_o && n < 8);
    if (!rply_o) begin
      n_total++;
      $display("FAIL %s_timeout: rply_o=0 after %0d cycles, expected 1", nm, n);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d, input logic bt);
    int n;
    addr_i = a; data_i = d; wtbt_i = bt; dout_i = 1'b1; sync_i = 1'b1;
    wait_rply("write", n);
    sync_i = 1'b0; dout_i = 1'b0; wtbt_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [15:0] exp, input string nm);
    int n;
    exp_name.push_back(nm);
    exp_val.push_back(exp);
    addr_i = a; din_i = 1'b1; sync_i = 1'b1;
    wait_rply(nm, n);
    sync_i = 1'b0; din_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_iack();
    int n;
    exp_name.push_back("iack_vector");
    exp_val.push_back(VEC);
    addr_i = 16'h0000; iako_i = 1'b1; din_i = 1'b1; sync_i = 1'b1;
    wait_rply("iack", n);
    check("iack_latency", 16'(n), 16'd1);
    check("iack_virq_cleared", {15'd0, virq_o}, 16'd0);
    sync_i = 1'b0; din_i = 1'b0; iako_i = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    reset_n = 1'b0; ce = 1'b1;
    addr_i = '0; data_i = '0;
    sync_i = 1'b0; din_i = 1'b0; dout_i = 1'b0; wtbt_i = 1'b0; iako_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    check("reset_rply", {15'd0, rply_o}, 16'd0);
    check("reset_virq", {15'd0, virq_o}, 16'd0);
    bus_read(A_RELOAD, 16'h0000, "reset_reload");
    bus_read(A_COUNT,  16'h0000, "reset_count");
    bus_read(A_CSR,    16'h0000, "reset_csr");

    // Byte lanes, read-only COUNT, CSR mask
    bus_write(A_RELOAD, 16'h1234, 1'b0);
    bus_write(A_RELOAD + 16'd1, 16'hABAB, 1'b1);
    bus_read(A_RELOAD, 16'hAB34, "byte_write_high");
    bus_write(A_RELOAD, 16'hCDCD, 1'b1);
    bus_read(A_RELOAD + 16'd1, 16'hABCD, "byte_write_low");
    bus_write(A_COUNT, 16'h5555, 1'b0);
    bus_read(A_COUNT, 16'h0000, "count_read_only");
    bus_write(A_CSR, 16'hFFF8, 1'b0);
    bus_read(A_CSR, 16'h0088, "csr_mask");
    bus_write(A_CSR, 16'h0000, 1'b0);

    // Periodic run: RELOAD=3, RUN|IE, expiry 16 ce-edges after write edge W
    bus_write(A_RELOAD, 16'h0003, 1'b0);
    bus_write(A_CSR, 16'h0005, 1'b0);            // commits at W, now W+1
    repeat (14) @(posedge clk); #1;              // W+15
    check("virq_before_expiry", {15'd0, virq_o}, 16'd0);
    @(posedge clk); #1;                          // W+16
    check("virq_at_expiry", {15'd0, virq_o}, 16'd1);
    bus_read(A_CSR, 16'h0085, "csr_after_expiry");      // -> W+18
    bus_read(A_COUNT, 16'h0003, "count_reloaded");      // -> W+20

    // Interrupt acknowledge
    bus_iack();                                  // -> W+22

    // CSR write with EXP=0 on the expiry edge W+32
    repeat (9) @(posedge clk); #1;               // W+31
    bus_write(A_CSR, 16'h0005, 1'b0);            // -> W+33
    check("virq_reraised", {15'd0, virq_o}, 16'd1);
    bus_read(A_CSR, 16'h0085, "exp_wins_over_clear");   // -> W+35
    bus_write(A_CSR, 16'h0005, 1'b0);            // W+36, no expiry
    bus_read(A_CSR, 16'h0005, "exp_cleared");           // -> W+39
    check("virq_held_ie1", {15'd0, virq_o}, 16'd1);
    bus_write(A_CSR, 16'h0001, 1'b0);            // W+40, IE=0, RUN stays 1
    check("virq_cleared_ie0", {15'd0, virq_o}, 16'd0);
    bus_read(A_COUNT, 16'h0001, "no_reload_on_rewrite"); // -> W+43
    repeat (2) @(posedge clk); #1;
    bus_write(A_CSR, 16'h0000, 1'b0);            // stop

    // One-shot: RELOAD=2, RUN|ONESHOT committed at S, expiry at S+12
    bus_write(A_RELOAD, 16'h0002, 1'b0);
    bus_write(A_CSR, 16'h0003, 1'b0);            // -> S+1
    repeat (10) @(posedge clk); #1;              // S+11
    bus_read(A_CSR, 16'h0003, "oneshot_before_expiry"); // -> S+13
    bus_read(A_CSR, 16'h0082, "oneshot_expired");
    bus_read(A_COUNT, 16'h0000, "oneshot_count_zero");
    check("oneshot_virq_ie0", {15'd0, virq_o}, 16'd0);
    bus_write(A_CSR, 16'h0002, 1'b0);
    repeat (40) @(posedge clk); #1;
    bus_read(A_CSR, 16'h0002, "oneshot_no_reexpiry");
    bus_read(A_COUNT, 16'h0000, "oneshot_count_holds");

    // RELOAD=0 periodic: expiry on every tick, RUN|IE committed at P
    bus_write(A_RELOAD, 16'h0000, 1'b0);
    bus_write(A_CSR, 16'h0005, 1'b0);            // -> P+1
    repeat (2) @(posedge clk); #1;               // P+3
    check("reload0_virq_before", {15'd0, virq_o}, 16'd0);
    @(posedge clk); #1;                          // P+4
    check("reload0_virq_first_tick", {15'd0, virq_o}, 16'd1);
    bus_read(A_CSR, 16'h0085, "reload0_csr");
    bus_read(A_COUNT, 16'h0000, "reload0_count");

    // Reset pulse mid-cycle with rply_o=1 and the timer running
    exp_name.push_back("pre_reset_csr");
    exp_val.push_back(16'h0085);
    addr_i = A_CSR; din_i = 1'b1; sync_i = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_rply", {15'd0, rply_o}, 16'd1);
    check("pre_reset_virq", {15'd0, virq_o}, 16'd1);
    reset_n = 1'b0; sync_i = 1'b0; din_i = 1'b0;
    #2;
    check("in_reset_rply", {15'd0, rply_o}, 16'd0);
    check("in_reset_virq", {15'd0, virq_o}, 16'd0);
    check("in_reset_sel", {15'd0, sel_o}, 16'd0);
    check("in_reset_data", data_o, 16'h0000);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_rply", {15'd0, rply_o}, 16'd0);
    check("post_reset_virq", {15'd0, virq_o}, 16'd0);
    bus_read(A_COUNT,  16'h0000, "post_reset_count");
    bus_read(A_CSR,    16'h0000, "post_reset_csr");
    bus_read(A_RELOAD, 16'h0000, "post_reset_reload");

    repeat (2) @(posedge clk); #1;
    check("scoreboard_drain", 16'(exp_val.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bk_timer.md
BK_TIMER -- requirements
Module: bk_timer

Interface
REQ-001 Parameter BASE_ADDR, default 16'o177706, is the word address of the first of three registers: RELOAD at +0, COUNT at +2, CSR at +4.
REQ-002 Parameter PRESCALE, default 128, is the number of ce-cycles per count tick when the CSR DIV bit is 0.
REQ-003 Parameter VECTOR, default 16'o000100, is the interrupt vector returned on acknowledge.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port ce, input, 1 bit: clock enable; state advances only on ce=1 edges.
REQ-007 Port addr_i, input, 16 bits: bus address from the CPU.
REQ-008 Port data_i, input, 16 bits: write data, already byte-replicated by the initiator.
REQ-009 Port sync_i, din_i, dout_i, wtbt_i, inputs, 1 bit each: bus strobes, with wtbt_i meaning byte operation.
REQ-010 Port iako_i, input, 1 bit: interrupt acknowledge; din_i is asserted with it.
REQ-011 Port data_o, output, 16 bits: read data or vector, valid while sel_o=1.
REQ-012 Port sel_o, output, 1 bit: combinational select; 1 when (register hit & din_i) or (iako_i & din_i & irq_pend).
REQ-013 Port rply_o, output, 1 bit: bus reply.
REQ-014 Port virq_o, output, 1 bit: vectored interrupt request, equal to irq_pend.

Function
REQ-015 A register hit is sync_i & addr_i[15:1] matching one of the three register word addresses.
REQ-016 rply_o is set on the first ce-edge where sync_i=1, sync_i was 0 at the previous ce-edge, and (hit or (iako_i & irq_pend)) holds; rply_o clears on the first ce-edge with sync_i=0.
REQ-017 A write commits exactly once per bus cycle, on the ce-edge where rply_o sets with dout_i=1.
REQ-018 Byte writes (wtbt_i=1) update only the high byte when addr_i[0]=1, else only the low byte; word writes update all 16 bits.
REQ-019 RELOAD is a 16-bit read/write register.
REQ-020 COUNT is read-only; writes to COUNT are ignored but still receive a reply.
REQ-021 CSR bit layout: bit0 RUN, bit1 ONESHOT, bit2 IE, bit3 DIV (1 = PRESCALE*16), bit7 EXP; all other bits read 0.
REQ-022 A CSR write with RUN changing 0->1 loads COUNT from RELOAD and clears the prescaler in the same edge.
REQ-023 While RUN=1 the prescaler counts ce-edges and emits a tick on terminal count; COUNT decrements by 1 per tick.
REQ-024 Expiry is a tick while COUNT==0; at expiry EXP is set and irq_pend is set if IE=1.
REQ-025 At expiry, if ONESHOT=1, RUN clears and COUNT holds 0; otherwise COUNT reloads from RELOAD, with no wrap to 16'hFFFF.
REQ-026 RELOAD=0 with ONESHOT=0 produces an expiry on every tick.
REQ-027 Writing EXP=0 clears EXP; an expiry in the same edge wins, leaving EXP=1.
REQ-028 irq_pend clears on the ce-edge where rply_o sets during an iako_i cycle; a CSR write with IE=0 also clears it; expiry in the same edge wins.
REQ-029 During an acknowledge, data_o = VECTOR; otherwise data_o = the addressed register; byte reads return the full word.
REQ-030 A CSR write while RUN=1 that leaves RUN=1 does not reload COUNT or the prescaler.

Reset
REQ-031 reset_n=0 asynchronously clears RELOAD, COUNT, CSR, the prescaler, irq_pend, rply_o and the sync sample to 0.
REQ-032 reset_n asserted mid-cycle aborts any bus cycle; rply_o and virq_o are 0 on release.

Structure
REQ-033 The register offsets, CSR bit positions and default VECTOR shall be constants in shared package bk_pkg.
REQ-034 The prescaler shall be sub-module bk_timer_prescaler, with inputs clk, reset_n, ce, clr, div16 and output tick.

Verification
REQ-035 The bench shall cover: RELOAD=3, CSR=RUN|IE, PRESCALE=4 -> first expiry 16 ce-edges after the write edge, EXP=1, virq_o=1, COUNT=3.
REQ-036 The bench shall cover: ONESHOT|RUN, RELOAD=2 -> one expiry, then RUN=0, COUNT=0 holds, and no further EXP after it is cleared.
REQ-037 The bench shall cover: iako_i cycle while virq_o=1 -> data_o=16'o000100, rply_o one ce after SYNC rises, virq_o=0 after the reply.
REQ-038 The bench shall cover: byte write of 16'hABAB to BASE_ADDR+1 with RELOAD=16'h1234 -> RELOAD=16'hAB34.
REQ-039 The bench shall cover: a CSR write with EXP=0 in the same edge as an expiry -> EXP=1.
REQ-040 The bench shall cover: reset_n pulse while rply_o=1 and the counter is running -> all outputs 0, and COUNT=0 after release.
